// File: rtl/phase_a_pkg.sv
// Shared definitions for the phase-A reduction scheduler: default sizes,
// FSM state encoding and sequencing constants.
package phase_a_pkg;

    // Operand/modulus width and launch-to-result abort limit.
    localparam int SIZE_DEF    = 3072;
    localparam int TIMEOUT_DEF = 64;

    // Width of the Montgomery constant handed to the datapath.
    localparam int M_PRIME_W   = 66;

    // dp_en is held for two cycles so the datapath's two-flop edge
    // detector sees it; three low cycles afterwards guarantee a clean
    // rising edge for the next launch.
    localparam int LAUNCH_CYC  = 2;
    localparam int GAP_CYC     = 3;

    // FSM state encoding.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;

    // Next round-robin priority holder after serving the given one-hot grant:
    // serving requester 0 hands priority to requester 1 and vice versa.
    function automatic logic rr_next_ptr(input logic [1:0] served);
        return served[0];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester that holds
// priority; it moves to the other requester whenever a grant is accepted.
module rr_arb2
    import phase_a_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic ptr;

    // Priority-ordered one-hot grant; the pointer side is looked at first.
    always_comb begin
        grant = 2'b00;
        if (ptr == 1'b0) begin
            if (req[0])      grant = 2'b01;
            else if (req[1]) grant = 2'b10;
        end else begin
            if (req[1])      grant = 2'b10;
            else if (req[0]) grant = 2'b01;
        end
    end

    // Hand priority to the other requester once a grant is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (accept && (grant != 2'b00)) begin
            ptr <= rr_next_ptr(grant);
        end
    end

endmodule

// File: rtl/phase_a_scheduler.sv
// Phase-A scheduler: arbitrates two requesters onto one external reduction
// datapath, sequences the dp_en launch pulse, waits for the result with a
// timeout, and returns the result with a one-cycle done pulse.
module phase_a_scheduler
    import phase_a_pkg::*;
#(
    parameter int SIZE    = SIZE_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req,
    input  logic [SIZE-1:0]      a0,
    input  logic [SIZE-1:0]      a1,
    input  logic                 cfg_we,
    input  logic [SIZE-1:0]      cfg_m,
    input  logic [SIZE+1:0]      cfg_m_n,
    input  logic [M_PRIME_W-1:0] cfg_m_prime,
    input  logic                 err_clr,
    output logic [SIZE-1:0]      dp_a,
    output logic [SIZE-1:0]      dp_m,
    output logic [SIZE+1:0]      dp_m_n,
    output logic [M_PRIME_W-1:0] dp_m_prime,
    output logic                 dp_en,
    input  logic [SIZE-1:0]      dp_new_a,
    input  logic                 dp_en_out,
    output logic [1:0]           gnt,
    output logic [1:0]           done,
    output logic [SIZE-1:0]      res,
    output logic                 busy,
    output logic                 err_timeout
);

    // One shared counter covers LAUNCH, WAIT and GAP; it must reach
    // TIMEOUT-1 and also GAP_CYC-1.
    localparam int CNT_W = ($clog2(TIMEOUT) < 2) ? 2 : $clog2(TIMEOUT);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       arb_gnt;

    logic launch;
    logic launch_end;
    logic wait_hit;
    logic wait_expire;
    logic gap_end;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .accept (launch),
        .grant  (arb_gnt)
    );

    // Transition qualifiers; dp_en_out only counts while waiting.
    always_comb begin
        launch      = (state == ST_IDLE)   && (req != 2'b00);
        launch_end  = (state == ST_LAUNCH) && (cnt == CNT_W'(LAUNCH_CYC - 1));
        wait_hit    = (state == ST_WAIT)   && dp_en_out;
        wait_expire = (state == ST_WAIT)   && !dp_en_out
                      && (cnt == CNT_W'(TIMEOUT - 1));
        gap_end     = (state == ST_GAP)    && (cnt == CNT_W'(GAP_CYC - 1));
    end

    assign busy = (state != ST_IDLE);

    // State register and the shared phase counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (launch) state <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    if (launch_end) begin
                        state <= ST_WAIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (wait_hit) begin
                        state <= ST_DONE;
                        cnt   <= '0;
                    end else if (wait_expire) begin
                        state <= ST_GAP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_GAP;
                    cnt   <= '0;
                end
                ST_GAP: begin
                    if (gap_end) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Modulus constants load only in IDLE, so they are frozen for the
    // whole operation; a same-cycle launch already sees the new values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_m       <= '0;
            dp_m_n     <= '0;
            dp_m_prime <= '0;
        end else if ((state == ST_IDLE) && cfg_we) begin
            dp_m       <= cfg_m;
            dp_m_n     <= cfg_m_n;
            dp_m_prime <= cfg_m_prime;
        end
    end

    // Operand capture, grant hold and the two-cycle dp_en launch pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_a  <= '0;
            gnt   <= 2'b00;
            dp_en <= 1'b0;
        end else begin
            if (launch) begin
                dp_a  <= arb_gnt[1] ? a1 : a0;
                gnt   <= arb_gnt;
                dp_en <= 1'b1;
            end
            if (launch_end) begin
                dp_en <= 1'b0;
            end
            if (wait_expire || (state == ST_DONE)) begin
                gnt <= 2'b00;
            end
        end
    end

    // Result capture and the one-cycle done pulse to the granted requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res  <= '0;
            done <= 2'b00;
        end else begin
            done <= 2'b00;
            if (wait_hit) begin
                res  <= dp_new_a;
                done <= gnt;
            end
        end
    end

    // Sticky timeout flag; a new timeout beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout <= 1'b0;
        end else if (wait_expire) begin
            err_timeout <= 1'b1;
        end else if (err_clr) begin
            err_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_phase_a_scheduler.sv
// Directed bench for phase_a_scheduler: the datapath is played by the
// stimulus sequence, which raises dp_en_out with a chosen result.
module tb_phase_a_scheduler;

    localparam int SIZE        = 16;
    localparam int TIMEOUT     = 64;
    localparam int MPW         = 66;
    localparam int WAIT_LAT    = 3;
    localparam int MIN_SPACING = 2 + WAIT_LAT + 1 + 3;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req;
    logic [SIZE-1:0]  a0;
    logic [SIZE-1:0]  a1;
    logic             cfg_we;
    logic [SIZE-1:0]  cfg_m;
    logic [SIZE+1:0]  cfg_m_n;
    logic [MPW-1:0]   cfg_m_prime;
    logic             err_clr;
    logic [SIZE-1:0]  dp_a;
    logic [SIZE-1:0]  dp_m;
    logic [SIZE+1:0]  dp_m_n;
    logic [MPW-1:0]   dp_m_prime;
    logic             dp_en;
    logic [SIZE-1:0]  dp_new_a;
    logic             dp_en_out;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic [SIZE-1:0]  res;
    logic             busy;
    logic             err_timeout;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_launch = -1;
    int done_seen   = 0;

    phase_a_scheduler #(
        .SIZE    (SIZE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .a0          (a0),
        .a1          (a1),
        .cfg_we      (cfg_we),
        .cfg_m       (cfg_m),
        .cfg_m_n     (cfg_m_n),
        .cfg_m_prime (cfg_m_prime),
        .err_clr     (err_clr),
        .dp_a        (dp_a),
        .dp_m        (dp_m),
        .dp_m_n      (dp_m_n),
        .dp_m_prime  (dp_m_prime),
        .dp_en       (dp_en),
        .dp_new_a    (dp_new_a),
        .dp_en_out   (dp_en_out),
        .gnt         (gnt),
        .done        (done),
        .res         (res),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch through DONE with a 3-cycle datapath response.
    task automatic do_op(input logic [1:0] eg, input logic [SIZE-1:0] ea,
                         input logic [SIZE-1:0] r, input string tag);
        step();
        chk({tag, " gnt"}, gnt, eg);
        chk({tag, " dp_a"}, dp_a, ea);
        chk({tag, " dp_en1"}, dp_en, 1'b1);
        if (last_launch >= 0)
            chk({tag, " spacing"}, (cyc - last_launch) >= MIN_SPACING, 1'b1);
        last_launch = cyc;
        step();
        chk({tag, " dp_en2"}, dp_en, 1'b1);
        step();
        chk({tag, " dp_en_low"}, dp_en, 1'b0);
        chk({tag, " done_early"}, done, 2'b00);
        step();
        step();
        dp_en_out = 1'b1;
        dp_new_a  = r;
        step();
        dp_en_out = 1'b0;
        chk({tag, " done"}, done, eg);
        chk({tag, " res"}, res, r);
    endtask

    // DONE -> GAP -> IDLE.
    task automatic gap_out(input string tag);
        step();
        chk({tag, " done_clr"}, done, 2'b00);
        chk({tag, " gnt_clr"}, gnt, 2'b00);
        step();
        step();
        chk({tag, " gap_busy"}, busy, 1'b1);
        chk({tag, " gap_dp_en"}, dp_en, 1'b0);
        step();
        chk({tag, " idle"}, busy, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        req         = 2'b00;
        a0          = '0;
        a1          = '0;
        cfg_we      = 1'b0;
        cfg_m       = '0;
        cfg_m_n     = '0;
        cfg_m_prime = '0;
        err_clr     = 1'b0;
        dp_new_a    = '0;
        dp_en_out   = 1'b0;

        // Reset state
        step();
        step();
        chk("rst gnt", gnt, 2'b00);
        chk("rst done", done, 2'b00);
        chk("rst busy", busy, 1'b0);
        chk("rst dp_en", dp_en, 1'b0);
        chk("rst err", err_timeout, 1'b0);
        chk("rst res", res, 16'h0);
        chk("rst dp_m", dp_m, 16'h0);
        rst_n = 1'b1;
        step();

        // Config load in IDLE
        cfg_we      = 1'b1;
        cfg_m       = 16'h000D;
        cfg_m_n     = 18'h3FFF3;
        cfg_m_prime = 66'h2_0000_0000_0000_0003;
        step();
        cfg_we = 1'b0;
        chk("cfg dp_m", dp_m, 16'h000D);
        chk("cfg dp_m_n", dp_m_n, 18'h3FFF3);
        chk("cfg dp_m_prime", dp_m_prime, 66'h2_0000_0000_0000_0003);

        // Single operation, result 0x7 twelve cycles after launch
        req = 2'b01;
        a0  = 16'h0005;
        step();
        chk("t1 gnt", gnt, 2'b01);
        chk("t1 dp_a", dp_a, 16'h0005);
        chk("t1 dp_en1", dp_en, 1'b1);
        chk("t1 busy", busy, 1'b1);
        step();
        chk("t1 dp_en2", dp_en, 1'b1);
        step();
        chk("t1 dp_en_low", dp_en, 1'b0);
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done != 2'b00 || dp_en != 1'b0) done_seen++;
        end
        chk("t1 quiet_wait", done_seen, 0);
        dp_en_out = 1'b1;
        dp_new_a  = 16'h0007;
        step();
        dp_en_out = 1'b0;
        chk("t1 done", done, 2'b01);
        chk("t1 res", res, 16'h0007);
        chk("t1 gnt_held", gnt, 2'b01);
        req = 2'b00;
        gap_out("t1");
        chk("t1 res_stable", res, 16'h0007);

        // Spurious dp_en_out in IDLE
        dp_en_out = 1'b1;
        dp_new_a  = 16'h0055;
        step();
        dp_en_out = 1'b0;
        chk("spur res", res, 16'h0007);
        chk("spur done", done, 2'b00);
        chk("spur busy", busy, 1'b0);

        // cfg_we during WAIT ignored; req dropped mid-op still completes
        req = 2'b01;
        a0  = 16'h0033;
        step();
        chk("cw gnt", gnt, 2'b01);
        req = 2'b00;
        step();
        step();
        cfg_we      = 1'b1;
        cfg_m       = 16'h000B;
        cfg_m_n     = 18'h3FFF5;
        cfg_m_prime = 66'h1;
        step();
        cfg_we = 1'b0;
        chk("cw dp_m_kept", dp_m, 16'h000D);
        chk("cw dp_m_n_kept", dp_m_n, 18'h3FFF3);
        dp_en_out = 1'b1;
        dp_new_a  = 16'h0044;
        step();
        dp_en_out = 1'b0;
        chk("cw done", done, 2'b01);
        chk("cw res", res, 16'h0044);
        chk("cw dp_a_const", dp_a, 16'h0033);
        gap_out("cw");

        // cfg_we and req=10 in the same IDLE cycle
        cfg_we = 1'b1;
        req    = 2'b10;
        a1     = 16'h0066;
        step();
        cfg_we = 1'b0;
        chk("ci dp_m", dp_m, 16'h000B);
        chk("ci dp_m_n", dp_m_n, 18'h3FFF5);
        chk("ci dp_m_prime", dp_m_prime, 66'h1);
        chk("ci gnt", gnt, 2'b10);
        chk("ci dp_a", dp_a, 16'h0066);
        step();
        step();
        dp_en_out = 1'b1;
        dp_new_a  = 16'h0077;
        step();
        dp_en_out = 1'b0;
        chk("ci done", done, 2'b10);
        chk("ci res", res, 16'h0077);
        chk("ci dp_m_const", dp_m, 16'h000B);
        req = 2'b00;
        gap_out("ci");

        // Both requesting continuously: alternating grants
        req = 2'b11;
        a0  = 16'h0011;
        a1  = 16'h0022;
        last_launch = -1;
        do_op(2'b01, 16'h0011, 16'h0101, "rr0");
        gap_out("rr0");
        do_op(2'b10, 16'h0022, 16'h0202, "rr1");
        gap_out("rr1");
        do_op(2'b01, 16'h0011, 16'h0303, "rr2");
        gap_out("rr2");
        do_op(2'b10, 16'h0022, 16'h0404, "rr3");
        req = 2'b00;
        gap_out("rr3");

        // Timeout: no dp_en_out ever
        req = 2'b01;
        a0  = 16'h0099;
        step();
        chk("to gnt", gnt, 2'b01);
        step();
        step();
        done_seen = 0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            step();
            if (done != 2'b00) done_seen++;
        end
        chk("to err_early", err_timeout, 1'b0);
        step();
        chk("to err_set", err_timeout, 1'b1);
        chk("to done", done, 2'b00);
        chk("to gnt_clr", gnt, 2'b00);
        chk("to busy", busy, 1'b1);
        chk("to no_done", done_seen, 0);
        chk("to res_kept", res, 16'h0404);
        req     = 2'b00;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("to err_clr", err_timeout, 1'b0);
        step();
        step();
        chk("to idle", busy, 1'b0);

        // Timeout coinciding with err_clr: set wins
        req     = 2'b01;
        a0      = 16'h009A;
        err_clr = 1'b1;
        step();
        step();
        step();
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        chk("tc err_early", err_timeout, 1'b0);
        step();
        chk("tc set_wins", err_timeout, 1'b1);
        step();
        chk("tc cleared", err_timeout, 1'b0);
        err_clr = 1'b0;
        req     = 2'b00;
        step();
        step();
        chk("tc idle", busy, 1'b0);

        // Reset during WAIT
        req = 2'b10;
        a1  = 16'h0012;
        step();
        step();
        step();
        step();
        chk("rw busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rw gnt", gnt, 2'b00);
        chk("rw busy", busy, 1'b0);
        chk("rw dp_en", dp_en, 1'b0);
        chk("rw dp_a", dp_a, 16'h0);
        chk("rw dp_m", dp_m, 16'h0);
        chk("rw dp_m_prime", dp_m_prime, 66'h0);
        chk("rw res", res, 16'h0);
        chk("rw done", done, 2'b00);
        step();
        step();
        chk("rw done_held", done, 2'b00);
        rst_n = 1'b1;
        req   = 2'b01;
        a0    = 16'h0021;
        last_launch = -1;
        do_op(2'b01, 16'h0021, 16'h003C, "ar");
        req = 2'b00;
        gap_out("ar");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
